// File: rtl/slave_link_rx_pkg.sv
// rtl/slave_link_rx_pkg.sv - shared packet types and default sizes for the serial link receiver
package slave_link_rx_pkg;

    typedef enum logic [1:0] {
        PKT_READY     = 2'b00,
        PKT_DATA      = 2'b01,
        PKT_GAME_LOST = 2'b10,
        PKT_ACK       = 2'b11
    } pkt_type_t;

    localparam int LANE_BITS_DEFAULT      = 16;
    localparam int TIMEOUT_CYCLES_DEFAULT = 2000;

    // Four data lanes plus the header lane; the header sits at the top index.
    localparam int NUM_LANES = 5;
    localparam int HDR_LANE  = 4;

endpackage

// File: rtl/slave_link_rx_sync_edge_det.sv
// rtl/slave_link_rx_sync_edge_det.sv - two-stage synchronizer with rising-edge pulse
module slave_link_rx_sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] warm_q;

    // Synchronize the input, remember the previous level, and hold off edge
    // detection until the pipeline has refilled after reset so a line that was
    // already high does not look like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            warm_q <= 2'd0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    assign rise = sync_q & ~prev_q & (warm_q == 2'd3);

endmodule

// File: rtl/slave_link_rx.sv
// rtl/slave_link_rx.sv - five-lane serial frame receiver with parity, dedup and timeout
module slave_link_rx
    import slave_link_rx_pkg::*;
#(
    parameter int LANE_BITS      = LANE_BITS_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_clk_in,
    input  logic                 serial_in_h,
    input  logic                 serial_in_0,
    input  logic                 serial_in_1,
    input  logic                 serial_in_2,
    input  logic                 serial_in_3,
    output logic                 pkt_valid,
    output logic [1:0]           pkt_type,
    output logic                 pkt_seq,
    output logic                 pkt_dup,
    output logic [LANE_BITS-1:0] lane_data_0,
    output logic [LANE_BITS-1:0] lane_data_1,
    output logic [LANE_BITS-1:0] lane_data_2,
    output logic [LANE_BITS-1:0] lane_data_3,
    output logic                 ack_req,
    output logic                 ack_req_seq,
    output logic                 ack_rcvd,
    output logic                 ack_rcvd_seq,
    output logic                 frame_err,
    output logic                 busy,
    output logic [3:0]           pkt_cnt,
    output logic [3:0]           err_cnt
);

    localparam int SR_W  = LANE_BITS + 1;
    localparam int CNT_W = $clog2(LANE_BITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK
    } state_t;

    state_t                             state;
    logic [CNT_W-1:0]                   bit_cnt;
    logic [TMO_W-1:0]                   tmo_cnt;
    logic [NUM_LANES-1:0]               lane_raw;
    logic [NUM_LANES-1:0]               lane_meta;
    logic [NUM_LANES-1:0]               lane_sync;
    logic [NUM_LANES-1:0][SR_W-1:0]     sr;
    logic [NUM_LANES-1:0][SR_W-1:0]     sr_next;
    logic [NUM_LANES-1:0]               lane_ok;
    logic                               frame_ok;
    pkt_type_t                          rx_type;
    logic                               rx_seq;
    logic                               serial_edge;
    pkt_type_t                          pkt_type_q;
    logic [3:0][LANE_BITS-1:0]          data_q;
    logic                               seen_data;
    logic                               last_seq;

    assign lane_raw = {serial_in_h, serial_in_3, serial_in_2, serial_in_1, serial_in_0};

    slave_link_rx_sync_edge_det u_clk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (serial_clk_in),
        .rise (serial_edge)
    );

    // Lane synchronizers match the clock path depth so samples line up with the edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_meta <= '0;
            lane_sync <= '0;
        end else begin
            lane_meta <= lane_raw;
            lane_sync <= lane_meta;
        end
    end

    // Next shift value per lane and the frame verdict it would give if this were the last bit.
    always_comb begin
        sr_next = '0;
        lane_ok = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sr_next[i] = {sr[i][SR_W-2:0], lane_sync[i]};
            lane_ok[i] = ~(^sr_next[i]);
        end
        frame_ok = &lane_ok;
        rx_type  = pkt_type_t'(sr_next[HDR_LANE][LANE_BITS -: 2]);
        rx_seq   = sr_next[HDR_LANE][LANE_BITS-2];
    end

    // Frame FSM: start detection, bit shifting, timeout, and registered result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            tmo_cnt      <= '0;
            sr           <= '0;
            pkt_valid    <= 1'b0;
            pkt_type_q   <= PKT_READY;
            pkt_seq      <= 1'b0;
            pkt_dup      <= 1'b0;
            data_q       <= '0;
            ack_req      <= 1'b0;
            ack_req_seq  <= 1'b0;
            ack_rcvd     <= 1'b0;
            ack_rcvd_seq <= 1'b0;
            frame_err    <= 1'b0;
            pkt_cnt      <= 4'd0;
            err_cnt      <= 4'd0;
            seen_data    <= 1'b0;
            last_seq     <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            ack_req   <= 1'b0;
            ack_rcvd  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (serial_edge && lane_sync[HDR_LANE]) begin
                        sr      <= '0;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                        state   <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (serial_edge) begin
                        sr      <= sr_next;
                        tmo_cnt <= '0;
                        if (bit_cnt == CNT_W'(LANE_BITS)) begin
                            state <= ST_CHECK;
                            if (!frame_ok) begin
                                frame_err <= 1'b1;
                                if (err_cnt != 4'hF) begin
                                    err_cnt <= err_cnt + 4'd1;
                                end
                            end else begin
                                pkt_valid  <= 1'b1;
                                pkt_cnt    <= pkt_cnt + 4'd1;
                                pkt_type_q <= rx_type;
                                pkt_seq    <= rx_seq;
                                if (rx_type == PKT_ACK) begin
                                    ack_rcvd     <= 1'b1;
                                    ack_rcvd_seq <= rx_seq;
                                    pkt_dup      <= 1'b0;
                                end else begin
                                    ack_req     <= 1'b1;
                                    ack_req_seq <= rx_seq;
                                    if (rx_type == PKT_DATA && seen_data && rx_seq == last_seq) begin
                                        pkt_dup <= 1'b1;
                                    end else begin
                                        pkt_dup <= 1'b0;
                                        if (rx_type == PKT_DATA) begin
                                            for (int i = 0; i < 4; i++) begin
                                                data_q[i] <= sr_next[i][SR_W-1:1];
                                            end
                                            last_seq  <= rx_seq;
                                            seen_data <= 1'b1;
                                        end
                                    end
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        frame_err <= 1'b1;
                        if (err_cnt != 4'hF) begin
                            err_cnt <= err_cnt + 4'd1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign pkt_type    = pkt_type_q;
    assign lane_data_0 = data_q[0];
    assign lane_data_1 = data_q[1];
    assign lane_data_2 = data_q[2];
    assign lane_data_3 = data_q[3];

endmodule

// File: tb/tb_slave_link_rx.sv
// tb/tb_slave_link_rx.sv - self-checking bench for slave_link_rx
module tb_slave_link_rx;

    localparam int LB   = 16;
    localparam int TMO  = 2000;
    localparam int HALF = 8;
    localparam int EV_START = 0;
    localparam int EV_CHECK = 1;
    localparam int EV_TMO   = 2;

    typedef struct {
        int               cyc;
        int               kind;
        logic [4:0][16:0] ln;
    } ev_t;

    ev_t q[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_clk_in = 1'b0;
    logic serial_in_h = 1'b0;
    logic serial_in_0 = 1'b0;
    logic serial_in_1 = 1'b0;
    logic serial_in_2 = 1'b0;
    logic serial_in_3 = 1'b0;

    logic          pkt_valid;
    logic [1:0]    pkt_type;
    logic          pkt_seq;
    logic          pkt_dup;
    logic [LB-1:0] lane_data_0;
    logic [LB-1:0] lane_data_1;
    logic [LB-1:0] lane_data_2;
    logic [LB-1:0] lane_data_3;
    logic          ack_req;
    logic          ack_req_seq;
    logic          ack_rcvd;
    logic          ack_rcvd_seq;
    logic          frame_err;
    logic          busy;
    logic [3:0]    pkt_cnt;
    logic [3:0]    err_cnt;

    slave_link_rx #(.LANE_BITS(LB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .serial_clk_in(serial_clk_in),
        .serial_in_h(serial_in_h), .serial_in_0(serial_in_0), .serial_in_1(serial_in_1),
        .serial_in_2(serial_in_2), .serial_in_3(serial_in_3),
        .pkt_valid(pkt_valid), .pkt_type(pkt_type), .pkt_seq(pkt_seq), .pkt_dup(pkt_dup),
        .lane_data_0(lane_data_0), .lane_data_1(lane_data_1),
        .lane_data_2(lane_data_2), .lane_data_3(lane_data_3),
        .ack_req(ack_req), .ack_req_seq(ack_req_seq), .ack_rcvd(ack_rcvd),
        .ack_rcvd_seq(ack_rcvd_seq), .frame_err(frame_err), .busy(busy),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #10 clk = ~clk;

    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Frame-level model of what the outputs must show.
    logic [1:0]  m_type;
    logic        m_seq, m_dup, m_rq_seq, m_rc_seq, m_seen, m_last, m_busy, busy_drop;
    logic [15:0] m_data [4];
    int          m_pkt, m_err;
    logic        e_valid, e_ackreq, e_ackrcvd, e_err;
    int          n_valid = 0, n_ackreq = 0, n_ackrcvd = 0, n_err = 0;

    task automatic model_reset();
        m_type = 0; m_seq = 0; m_dup = 0; m_rq_seq = 0; m_rc_seq = 0;
        m_seen = 0; m_last = 0; m_busy = 0; busy_drop = 0; m_pkt = 0; m_err = 0;
        for (int i = 0; i < 4; i++) m_data[i] = 16'h0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        ev_t        ev;
        bit         ok;
        logic [1:0] typ;
        logic       sq;
        e_valid = 0; e_ackreq = 0; e_ackrcvd = 0; e_err = 0;
        if (rst_q) begin
            model_reset();
            q.delete();
        end else begin
            if (busy_drop) begin
                m_busy = 0;
                busy_drop = 0;
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                ev = q.pop_front();
                if (ev.kind == EV_START) begin
                    m_busy = 1;
                end else if (ev.kind == EV_TMO) begin
                    e_err = 1;
                    m_busy = 0;
                    if (m_err < 15) m_err++;
                end else begin
                    busy_drop = 1;
                    ok = 1;
                    for (int i = 0; i < 5; i++) if (^ev.ln[i]) ok = 0;
                    if (!ok) begin
                        e_err = 1;
                        if (m_err < 15) m_err++;
                    end else begin
                        typ = ev.ln[4][16:15];
                        sq  = ev.ln[4][14];
                        e_valid = 1;
                        m_pkt = (m_pkt + 1) % 16;
                        m_type = typ;
                        m_seq = sq;
                        if (typ == 2'b11) begin
                            e_ackrcvd = 1; m_rc_seq = sq; m_dup = 0;
                        end else begin
                            e_ackreq = 1; m_rq_seq = sq;
                            m_dup = (typ == 2'b01) && m_seen && (sq == m_last);
                            if (typ == 2'b01 && !m_dup) begin
                                for (int i = 0; i < 4; i++) m_data[i] = ev.ln[i][16:1];
                                m_last = sq;
                                m_seen = 1;
                            end
                        end
                    end
                end
            end
        end
        if (chk_en) begin
            chk("pkt_valid", pkt_valid, e_valid);
            chk("ack_req", ack_req, e_ackreq);
            chk("ack_rcvd", ack_rcvd, e_ackrcvd);
            chk("frame_err", frame_err, e_err);
            chk("busy", busy, m_busy);
            chk("pkt_type", pkt_type, m_type);
            chk("pkt_seq", pkt_seq, m_seq);
            chk("pkt_dup", pkt_dup, m_dup);
            chk("ack_req_seq", ack_req_seq, m_rq_seq);
            chk("ack_rcvd_seq", ack_rcvd_seq, m_rc_seq);
            chk("pkt_cnt", pkt_cnt, m_pkt);
            chk("err_cnt", err_cnt, m_err);
            chk("lane_data_0", lane_data_0, m_data[0]);
            chk("lane_data_1", lane_data_1, m_data[1]);
            chk("lane_data_2", lane_data_2, m_data[2]);
            chk("lane_data_3", lane_data_3, m_data[3]);
            if (pkt_valid) n_valid++;
            if (ack_req) n_ackreq++;
            if (ack_rcvd) n_ackrcvd++;
            if (frame_err) n_err++;
        end
    end

    function automatic logic [16:0] lane_w(input logic [15:0] w);
        return {w, ^w};
    endfunction

    function automatic logic [4:0][16:0] mkf(input logic [1:0] t, input logic s,
                                             input logic [15:0] d0, input logic [15:0] d1,
                                             input logic [15:0] d2, input logic [15:0] d3);
        logic [4:0][16:0] f;
        f[0] = lane_w(d0);
        f[1] = lane_w(d1);
        f[2] = lane_w(d2);
        f[3] = lane_w(d3);
        f[4] = lane_w({t, s, 13'h0});
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [4:0] b);
        serial_in_0 = b[0]; serial_in_1 = b[1]; serial_in_2 = b[2];
        serial_in_3 = b[3]; serial_in_h = b[4];
    endtask

    // Start bit then nbits MSB-first bits; lanes change on the falling serial edge.
    task automatic send_frame(input logic [4:0][16:0] ln, input int nbits, input bit tail);
        logic [4:0] b;
        serial_clk_in = 0;
        set_lanes(5'b10000);
        tick(HALF);
        serial_clk_in = 1;
        q.push_back('{cyc + 3, EV_START, ln});
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            for (int l = 0; l < 5; l++) b[l] = ln[l][16-i];
            serial_clk_in = 0;
            set_lanes(b);
            tick(HALF);
            serial_clk_in = 1;
            if (tail && i == nbits - 1) begin
                if (nbits == 17) q.push_back('{cyc + 3, EV_CHECK, ln});
                else q.push_back('{cyc + TMO + 3, EV_TMO, ln});
            end
            tick(HALF);
        end
    endtask

    initial begin
        logic [4:0][16:0] f;
        int base;
        serial_clk_in = 1;
        serial_in_h = 1;
        rst = 1;
        tick(3);
        chk_en = 1;
        rst = 0;
        tick(12);
        chk("reset_busy", busy, 0);
        chk("reset_pkt_cnt", pkt_cnt, 0);

        f = mkf(2'b01, 1'b0, 16'hA5A5, 16'h0001, 16'hFFFF, 16'h1234);
        send_frame(f, 17, 1);
        tick(6);
        chk("d1_lane0", lane_data_0, 16'hA5A5);
        chk("d1_lane1", lane_data_1, 16'h0001);
        chk("d1_lane2", lane_data_2, 16'hFFFF);
        chk("d1_lane3", lane_data_3, 16'h1234);
        chk("d1_pkt_cnt", pkt_cnt, 1);
        chk("d1_valid_seen", n_valid, 1);
        chk("d1_ackreq_seen", n_ackreq, 1);
        chk("d1_dup", pkt_dup, 0);
        chk("d1_ackreq_seq", ack_req_seq, 0);

        send_frame(f, 17, 1);
        tick(6);
        chk("dup_flag", pkt_dup, 1);
        chk("dup_lane0", lane_data_0, 16'hA5A5);
        chk("dup_ackreq_seen", n_ackreq, 2);

        f = mkf(2'b01, 1'b1, 16'h00FF, 16'h0001, 16'hFFFF, 16'h1234);
        send_frame(f, 17, 1);
        tick(6);
        chk("seq1_dup", pkt_dup, 0);
        chk("seq1_lane0", lane_data_0, 16'h00FF);

        f = mkf(2'b11, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        send_frame(f, 17, 1);
        tick(6);
        chk("ack_rcvd_seen", n_ackrcvd, 1);
        chk("ack_rcvd_seq_lit", ack_rcvd_seq, 1);
        chk("ack_no_req", n_ackreq, 3);
        chk("ack_type", pkt_type, 2'b11);

        f = mkf(2'b01, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        f[2][0] = ~f[2][0];
        send_frame(f, 17, 1);
        tick(6);
        chk("perr_seen", n_err, 1);
        chk("perr_err_cnt", err_cnt, 1);
        chk("perr_valid_seen", n_valid, 4);
        chk("perr_lane2", lane_data_2, 16'hFFFF);

        f = mkf(2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        send_frame(f, 5, 1);
        tick(TMO + 10);
        chk("tmo_seen", n_err, 2);
        chk("tmo_busy", busy, 0);
        f = mkf(2'b10, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        send_frame(f, 17, 1);
        tick(6);
        chk("tmo_next_pkt_cnt", pkt_cnt, 5);
        chk("tmo_next_type", pkt_type, 2'b10);

        f = mkf(2'b01, 1'b1, 16'hBEEF, 16'h0, 16'h0, 16'h0);
        send_frame(f, 6, 0);
        serial_in_h = 1;
        rst = 1;
        tick(2);
        rst = 0;
        tick(12);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_lane0", lane_data_0, 16'h0);

        for (int k = 0; k < 17; k++) begin
            f = mkf(k[1:0], k[2], 16'(k * 3), 16'(k), 16'hF0F0, 16'(k + 7));
            f[k % 5][0] = ~f[k % 5][0];
            send_frame(f, 17, 1);
            tick(4);
        end
        chk("err_sat", err_cnt, 15);

        base = n_valid;
        for (int k = 0; k < 16; k++) begin
            f = mkf(k[1:0], k[0], 16'(k * 257), 16'h5A5A, 16'(k), 16'h8001);
            send_frame(f, 17, 1);
            tick(4);
        end
        chk("pkt_wrap", pkt_cnt, 0);
        chk("pkt_wrap_seen", n_valid - base, 16);
        chk("events_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/slave_link_rx.md
SLAVE_LINK_RX -- requirements
Module: slave_link_rx

Interface
REQ-001 Param LANE_BITS, 16, payload bits per lane per frame.
REQ-002 Param TIMEOUT_CYCLES, 2000, clk cycles without a serial clock rising edge before a frame is aborted.
REQ-003 clk  in  1  system clock (50 MHz); one clock domain.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 serial_clk_in  in  1  remote link clock (up to 100 kHz), asynchronous to clk.
REQ-006 serial_in_h, serial_in_0..3  in  1 each  header lane and four data lanes, asynchronous, launched on the remote clock's falling edge.
REQ-007 pkt_valid  out  1  one-cycle pulse: good frame accepted.
REQ-008 pkt_type  out  2  pkt_type_t: READY=00, DATA=01, GAME_LOST=10, ACK=11.
REQ-009 pkt_seq, pkt_dup  out  1 each  sequence bit; duplicate-DATA flag.
REQ-010 lane_data_0..3  out  LANE_BITS each  last accepted non-duplicate DATA payload.
REQ-011 ack_req, ack_req_seq  out  1 each  pulse requesting an ACK from the local sender, with the seq to echo.
REQ-012 ack_rcvd, ack_rcvd_seq  out  1 each  pulse on a good ACK frame, with its seq.
REQ-013 frame_err  out  1  one-cycle pulse on parity error or timeout.
REQ-014 busy  out  1  high while not IDLE.
REQ-015 pkt_cnt, err_cnt  out  4 each  good-frame count (wraps 15->0); error count (saturates at 15).

Function
REQ-016 Route serial_clk_in and all five lanes through identical 2-FF synchronizers, so lane samples stay aligned to the synchronized clock.
REQ-017 A "serial edge" is a 0->1 transition of the synchronized clock; it lasts one clk cycle, and lanes are sampled only on that cycle.
REQ-018 States: IDLE, RECV, CHECK.
REQ-019 IDLE: on a serial edge with header=1 (start bit), clear the shift registers and bit counter and go to RECV; data lanes are ignored on the start edge.
REQ-020 RECV: each serial edge shifts all five lanes in MSB-first; after LANE_BITS+1 edges, go to CHECK.
REQ-021 Header word field layout: MSBs [LANE_BITS-1:LANE_BITS-2] = type; next bit = seq; remaining bits reserved and ignored.
REQ-022 Frame check: the final bit of every lane is even parity over that lane's LANE_BITS bits; any lane mismatch is a frame error.
REQ-023 CHECK lasts exactly one cycle, then returns to IDLE; all result pulses assert during CHECK, one cycle after the final sampled edge.
REQ-024 A good frame pulses pkt_valid and increments pkt_cnt; pkt_type and pkt_seq hold until the next good frame.
REQ-025 Good DATA frame, seq equal to last accepted DATA seq, with a prior DATA frame already accepted: pkt_dup=1 and lane_data is not updated.
REQ-026 Any other good DATA frame: pkt_dup=0, lane_data updated, and the stored last seq updated.
REQ-027 A good READY, DATA (including duplicates) or GAME_LOST frame pulses ack_req with ack_req_seq = frame seq.
REQ-028 A good ACK frame pulses ack_rcvd only, with no ack_req.
REQ-029 A parity error pulses frame_err and increments err_cnt; pkt_valid, ack_req and ack_rcvd stay low and no data is updated.
REQ-030 Timeout: in RECV, TIMEOUT_CYCLES consecutive clk cycles with no serial edge pulse frame_err, increment err_cnt, and return to IDLE; partial data is discarded.
REQ-031 A serial edge and a timeout expiry in the same cycle: the edge wins and the timeout counter clears.
REQ-032 A start bit seen while busy is treated as ordinary data.

Reset
REQ-033 In any state, rst returns the block to IDLE next cycle and clears all outputs, counters, synchronizers, shift registers, stored seq and the seen-DATA flag.
REQ-034 Synchronizers clear to 0, so a line held high through reset produces no edge.

Structure
REQ-035 NetworkPkg holds pkt_type_t, LANE_BITS and TIMEOUT_CYCLES defaults; state enum is local.
REQ-036 One sub-module, sync_edge_det: 2-FF synchronizer plus rising-edge pulse, instantiated for the clock; lanes use plain synchronizers of matching depth.

Verification
REQ-037 DATA, seq=0, lanes 0..3 = 16'hA5A5/16'h0001/16'hFFFF/16'h1234 with correct parity -> pkt_valid=1, pkt_dup=0, lane_data matches, ack_req=1, ack_req_seq=0, pkt_cnt=1.
REQ-038 Same DATA frame resent with seq=0 -> pkt_dup=1, lane_data unchanged, ack_req=1; then seq=1 with lane_0=16'h00FF -> pkt_dup=0, lane_data_0=16'h00FF.
REQ-039 ACK frame, seq=1 -> ack_rcvd=1, ack_rcvd_seq=1, ack_req=0.
REQ-040 Lane 2 parity bit flipped -> frame_err=1, pkt_valid=0, err_cnt=1, lane_data unchanged.
REQ-041 Serial clock stopped after 5 bits -> frame_err exactly TIMEOUT_CYCLES cycles after the last edge, busy=0; the next good frame is accepted.
REQ-042 rst asserted mid-frame -> IDLE and outputs zero next cycle; 17 err_cnt events -> err_cnt=15; 16 good frames -> pkt_cnt=0.
